// File: rtl/instruction_memory_loader_if.sv
// Program-load stream and instruction-fetch bundle for instruction_memory_loader.
// master drives the load stream and fetch address; slave is the instruction store.
interface instruction_memory_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_data;
    logic                  load_last;
    logic                  load_ready;
    logic [ADDR_WIDTH-1:0] read_address;
    logic [7:0]            instruction;
    logic                  core_run;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  overflow;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        output read_address,
        input  load_ready,
        input  instruction,
        input  core_run,
        input  load_count,
        input  overflow
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        input  read_address,
        output load_ready,
        output instruction,
        output core_run,
        output load_count,
        output overflow
    );
endinterface

// File: rtl/instruction_memory_loader.sv
// Instruction store for the 8-bit core: byte-stream program load, then
// zero-latency fetch with unloaded words masked to a fill instruction.
module instruction_memory_loader #(
    parameter int         DEPTH      = 256,
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] FILL_INSTR = 8'h00
) (
    input logic                   clock,
    input logic                   clear,
    instruction_memory_loader_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] count;
    logic [ADDR_WIDTH:0] count_next;
    logic                ovf;
    logic                ovf_next;
    logic                accept;
    logic                write_en;
    logic                hit;
    logic [7:0]          mem [DEPTH];

    assign bus.load_ready = (state == LOAD) && !bus.load_start;
    assign accept         = bus.load_valid && bus.load_ready;

    always_comb begin
        state_next = state;
        count_next = count;
        ovf_next   = ovf;
        write_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            LOAD: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end else if (accept) begin
                    // Excess bytes are still handshaken so the
                    // stream never stalls; only the store is skipped.
                    if (count < DEPTH_C) begin
                        write_en   = 1'b1;
                        count_next = count + ONE;
                    end else begin
                        ovf_next = 1'b1;
                    end
                    if (bus.load_last) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    // Storage is never reset; stale words are hidden by count.
    always_ff @(posedge clock) begin
        if (write_en && !clear) begin
            mem[count[IW-1:0]] <= bus.load_data;
        end
    end

    assign hit = (state == RUN)
              && ({1'b0, bus.read_address} < count);

    assign bus.instruction = hit ? mem[bus.read_address[IW-1:0]]
                                 : FILL_INSTR;
    assign bus.core_run    = (state == RUN);
    assign bus.load_count  = count;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomized self-checking bench for instruction_memory_loader,
// with a full-depth instance and a DEPTH=4 instance for overflow.
module tb_instruction_memory_loader;
    localparam int BIG   = 256;
    localparam int SMALL = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    logic [7:0] model_img [$];

    instruction_memory_loader_if #(.ADDR_WIDTH(8)) bus ();
    instruction_memory_loader_if #(.ADDR_WIDTH(8)) sbus ();

    instruction_memory_loader #(
        .DEPTH(BIG), .ADDR_WIDTH(8), .FILL_INSTR(8'h00)
    ) u_dut (
        .clock(clk), .clear(rst), .bus(bus.slave)
    );

    instruction_memory_loader #(
        .DEPTH(SMALL), .ADDR_WIDTH(8), .FILL_INSTR(8'h00)
    ) u_small (
        .clock(clk), .clear(rst), .bus(sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_instr(input int a);
        if (a < model_img.size() && a < BIG) return model_img[a];
        return 8'h00;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic load_image(input logic [7:0] img [$], input bit gaps);
        int n;
        n = img.size();
        bus.load_start = 1'b1;
        bus.load_valid = 1'($urandom_range(0, 1));
        bus.load_data  = 8'($urandom);
        bus.load_last  = 1'b1;
        #1;
        vectors++;
        if (bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready got=%b exp=0", bus.load_ready);
        end
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        vectors++;
        if (bus.load_count !== 9'd0 || bus.core_run !== 1'b0
            || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL start_state cnt=%0d run=%b ovf=%b exp=0/0/0",
                     bus.load_count, bus.core_run, bus.overflow);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.load_valid = 1'b0;
                    bus.load_last  = 1'($urandom_range(0, 1));
                    bus.load_data  = 8'($urandom);
                    tick();
                    vectors++;
                    if (bus.load_count !== 9'(min_i(i, BIG))
                        || bus.core_run !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_hold cnt=%0d run=%b exp=%0d/0",
                                 bus.load_count, bus.core_run, min_i(i, BIG));
                    end
                end
            end
            bus.load_valid = 1'b1;
            bus.load_data  = img[i];
            bus.load_last  = (i == n - 1);
            #1;
            vectors++;
            if (bus.load_ready !== 1'b1 || bus.instruction !== 8'h00) begin
                errors++;
                $display("FAIL beat_ready rdy=%b ins=%h exp=1/00",
                         bus.load_ready, bus.instruction);
            end
            tick();
            vectors++;
            if (bus.load_count !== 9'(min_i(i + 1, BIG))
                || bus.overflow !== (i + 1 > BIG)
                || bus.core_run !== (i == n - 1)) begin
                errors++;
                $display("FAIL beat%0d cnt=%0d ovf=%b run=%b exp=%0d/%b/%b",
                         i, bus.load_count, bus.overflow, bus.core_run,
                         min_i(i + 1, BIG), (i + 1 > BIG), (i == n - 1));
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_img = img;
    endtask

    task automatic check_reads(input int extra);
        int addrs [$];
        int n;
        n = model_img.size();
        addrs.push_back(0);
        addrs.push_back(n - 1);
        addrs.push_back(n);
        addrs.push_back(255);
        for (int k = 0; k < extra; k++) addrs.push_back($urandom_range(0, 255));
        foreach (addrs[k]) begin
            if (addrs[k] < 0 || addrs[k] > 255) continue;
            bus.read_address = 8'(addrs[k]);
            #1;
            vectors++;
            if (bus.instruction !== exp_instr(addrs[k])) begin
                errors++;
                $display("FAIL read[%0d] got=%h exp=%h",
                         addrs[k], bus.instruction, exp_instr(addrs[k]));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.read_address = 8'h05;
        #1;
        vectors++;
        if (bus.core_run !== 1'b0 || bus.load_ready !== 1'b0
            || bus.load_count !== 9'd0 || bus.overflow !== 1'b0
            || bus.instruction !== 8'h00) begin
            errors++;
            $display("FAIL reset run=%b rdy=%b cnt=%0d ovf=%b ins=%h exp=0/0/0/0/00",
                     bus.core_run, bus.load_ready, bus.load_count,
                     bus.overflow, bus.instruction);
        end
        vectors++;
        if (sbus.core_run !== 1'b0 || sbus.load_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_small run=%b cnt=%0d exp=0/0",
                     sbus.core_run, sbus.load_count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] img [$];
        img = '{8'h41, 8'h82, 8'hC3};
        load_image(img, 1'b0);
        for (int a = 0; a < 4; a++) begin
            bus.read_address = 8'(a);
            #1;
            vectors++;
            if (bus.instruction !== exp_instr(a)) begin
                errors++;
                $display("FAIL basic_read[%0d] got=%h exp=%h",
                         a, bus.instruction, exp_instr(a));
            end
        end
        vectors++;
        if (bus.load_count !== 9'd3 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_run cnt=%0d rdy=%b exp=3/0",
                     bus.load_count, bus.load_ready);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = b0;
        bus.load_last  = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) begin
            bus.load_valid = 1'b0;
            bus.load_last  = 1'b1;
            tick();
            vectors++;
            if (bus.load_count !== 9'd1 || bus.core_run !== 1'b0) begin
                errors++;
                $display("FAIL gapped_idle cnt=%0d run=%b exp=1/0",
                         bus.load_count, bus.core_run);
            end
        end
        bus.load_valid = 1'b1;
        bus.load_data  = b1;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        vectors++;
        if (bus.load_count !== 9'd2 || bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL gapped_end cnt=%0d run=%b exp=2/1",
                     bus.load_count, bus.core_run);
        end
        model_img = '{b0, b1};
        check_reads(4);
    endtask

    task automatic test_overflow_small();
        logic [7:0] img [6];
        foreach (img[i]) img[i] = 8'($urandom);
        sbus.load_start = 1'b1;
        tick();
        sbus.load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sbus.load_valid = 1'b1;
            sbus.load_data  = img[i];
            sbus.load_last  = (i == 5);
            #1;
            vectors++;
            if (sbus.load_ready !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ready beat%0d got=%b exp=1", i, sbus.load_ready);
            end
            tick();
            vectors++;
            if (sbus.load_count !== 9'(min_i(i + 1, SMALL))
                || sbus.overflow !== (i + 1 > SMALL)
                || sbus.core_run !== (i == 5)) begin
                errors++;
                $display("FAIL ovf_beat%0d cnt=%0d ovf=%b run=%b exp=%0d/%b/%b",
                         i, sbus.load_count, sbus.overflow, sbus.core_run,
                         min_i(i + 1, SMALL), (i + 1 > SMALL), (i == 5));
            end
        end
        sbus.load_valid = 1'b0;
        sbus.load_last  = 1'b0;
        for (int a = 0; a < 8; a++) begin
            sbus.read_address = 8'(a);
            #1;
            vectors++;
            if (sbus.instruction !== ((a < SMALL) ? img[a] : 8'h00)) begin
                errors++;
                $display("FAIL ovf_read[%0d] got=%h exp=%h", a,
                         sbus.instruction, (a < SMALL) ? img[a] : 8'h00);
            end
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] img [$];
        for (int i = 0; i < BIG + 2; i++) img.push_back(8'($urandom));
        load_image(img, 1'b0);
        check_reads(8);
    endtask

    task automatic test_restart();
        logic [7:0] img [$];
        img = '{8'($urandom), 8'($urandom), 8'($urandom)};
        load_image(img, 1'b0);
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h99;
        bus.load_last  = 1'b1;
        #1;
        vectors++;
        if (bus.load_ready !== 1'b0 || bus.core_run !== 1'b1) begin
            errors++;
            $display("FAIL restart_same rdy=%b run=%b exp=0/1",
                     bus.load_ready, bus.core_run);
        end
        tick();
        bus.load_start = 1'b0;
        vectors++;
        if (bus.core_run !== 1'b0 || bus.load_count !== 9'd0
            || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL restart_next run=%b cnt=%0d ovf=%b exp=0/0/0",
                     bus.core_run, bus.load_count, bus.overflow);
        end
        bus.load_data = 8'h7F;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        vectors++;
        if (bus.core_run !== 1'b1 || bus.load_count !== 9'd1) begin
            errors++;
            $display("FAIL reload run=%b cnt=%0d exp=1/1",
                     bus.core_run, bus.load_count);
        end
        model_img = '{8'h7F};
        check_reads(2);
    endtask

    task automatic test_clear_mid_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'($urandom);
            bus.load_last  = 1'b0;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.core_run !== 1'b0 || bus.load_ready !== 1'b0
            || bus.load_count !== 9'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid run=%b rdy=%b cnt=%0d ovf=%b exp=0/0/0/0",
                     bus.core_run, bus.load_ready, bus.load_count, bus.overflow);
        end
        for (int i = 0; i < 3; i++) begin
            bus.load_valid   = 1'b1;
            bus.load_data    = 8'($urandom);
            bus.load_last    = (i == 2);
            bus.read_address = 8'(i);
            tick();
            vectors++;
            if (bus.load_count !== 9'd0 || bus.core_run !== 1'b0
                || bus.load_ready !== 1'b0 || bus.instruction !== 8'h00) begin
                errors++;
                $display("FAIL idle_ignore cnt=%0d run=%b rdy=%b ins=%h exp=0/0/0/00",
                         bus.load_count, bus.core_run, bus.load_ready,
                         bus.instruction);
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] img [$];
        for (int r = 0; r < 6; r++) begin
            img.delete();
            repeat ($urandom_range(1, 40)) img.push_back(8'($urandom));
            load_image(img, 1'b1);
            check_reads(6);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b0;
        bus.load_start   = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = 8'h00;
        bus.load_last    = 1'b0;
        bus.read_address = 8'h00;
        sbus.load_start   = 1'b0;
        sbus.load_valid   = 1'b0;
        sbus.load_data    = 8'h00;
        sbus.load_last    = 1'b0;
        sbus.read_address = 8'h00;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow_small();
        test_full_overflow();
        test_restart();
        test_clear_mid_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
